// File: rtl/lisnoc_dma_wb_arbiter_pkg.sv
// Shared constants for the DMA Wishbone master-port arbiter: Wishbone cycle/burst
// type encodings and the arbiter FSM state encoding.
package lisnoc_dma_wb_arbiter_pkg;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin search: first set bit of req after position last,
// wrapping modulo width.
module lisnoc_arb_rr #(
  parameter int unsigned width     = 2,
  parameter int unsigned ptr_width = 1
) (
  input  logic [width-1:0]     req,
  input  logic [ptr_width-1:0] last,
  output logic [ptr_width-1:0] winner,
  output logic                 any
);

  localparam int unsigned IW = (width > 1) ? $clog2(width) : 1;

  logic [IW-1:0] pos;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    pos    = '0;
    for (int unsigned off = 1; off <= width; off++) begin
      pos = IW'((32'(last) + off) % width);
      if (!any && req[pos]) begin
        any    = 1'b1;
        winner = ptr_width'(pos);
      end
    end
  end

endmodule

// File: rtl/lisnoc_dma_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among num_masters DMA
// requesters; ownership is held from grant until cyc drops or an end-of-burst ack.
module lisnoc_dma_wb_arbiter
  import lisnoc_dma_wb_arbiter_pkg::*;
#(
  parameter int unsigned num_masters      = 2,
  parameter int unsigned master_ptr_width = 1
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [num_masters-1:0]        m_wb_cyc_i,
  input  logic [num_masters-1:0]        m_wb_stb_i,
  input  logic [num_masters-1:0]        m_wb_we_i,
  input  logic [num_masters*32-1:0]     m_wb_adr_i,
  input  logic [num_masters*32-1:0]     m_wb_dat_i,
  input  logic [num_masters*4-1:0]      m_wb_sel_i,
  input  logic [num_masters*3-1:0]      m_wb_cti_i,
  input  logic [num_masters*2-1:0]      m_wb_bte_i,
  output logic [num_masters-1:0]        m_wb_ack_o,
  output logic [31:0]                   m_wb_dat_o,

  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [31:0]                   wb_adr_o,
  output logic [31:0]                   wb_dat_o,
  output logic [3:0]                    wb_sel_o,
  output logic [2:0]                    wb_cti_o,
  output logic [1:0]                    wb_bte_o,
  input  logic                          wb_ack_i,
  input  logic [31:0]                   wb_dat_i,

  output logic                          grant_valid,
  output logic [master_ptr_width-1:0]   grant_idx
);

  localparam int unsigned IW = (num_masters > 1) ? $clog2(num_masters) : 1;

  logic [0:0]                  state;
  logic [master_ptr_width-1:0] last_idx;
  logic [master_ptr_width-1:0] rr_winner;
  logic                        rr_any;
  logic [IW-1:0]               own;
  logic                        owner_ok;
  logic                        release_bus;

  lisnoc_arb_rr #(
    .width     (num_masters),
    .ptr_width (master_ptr_width)
  ) u_arb_rr (
    .req    (m_wb_cyc_i),
    .last   (last_idx),
    .winner (rr_winner),
    .any    (rr_any)
  );

  assign grant_valid = (state == ST_OWNED);
  assign m_wb_dat_o  = wb_dat_i;
  assign own         = IW'(grant_idx);
  assign owner_ok    = (32'(grant_idx) < num_masters);

  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_sel_o   = '0;
    wb_cti_o   = '0;
    wb_bte_o   = '0;
    m_wb_ack_o = '0;
    if (state == ST_OWNED && owner_ok) begin
      wb_cyc_o        = m_wb_cyc_i[own];
      wb_stb_o        = m_wb_stb_i[own];
      wb_we_o         = m_wb_we_i[own];
      wb_adr_o        = m_wb_adr_i[32*own +: 32];
      wb_dat_o        = m_wb_dat_i[32*own +: 32];
      wb_sel_o        = m_wb_sel_i[4*own +: 4];
      wb_cti_o        = m_wb_cti_i[3*own +: 3];
      wb_bte_o        = m_wb_bte_i[2*own +: 2];
      m_wb_ack_o[own] = wb_ack_i;
    end
  end

  // While owned the shared-port copies equal the owner's fields, so they decide release.
  assign release_bus = !wb_cyc_o || (wb_ack_i && (wb_cti_o == WB_CTI_EOB));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_idx  <= master_ptr_width'(num_masters - 1);
    end else if (state == ST_IDLE) begin
      if (rr_any) begin
        state     <= ST_OWNED;
        grant_idx <= rr_winner;
        last_idx  <= rr_winner;
      end
    end else if (release_bus) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_lisnoc_dma_wb_arbiter.sv
// Bench for lisnoc_dma_wb_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural ownership model.
module tb_lisnoc_dma_wb_arbiter;
  import lisnoc_dma_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  cyc, stb, we;
  logic [N*32-1:0] adr, dat;
  logic [N*4-1:0]  sel;
  logic [N*3-1:0]  cti;
  logic [N*2-1:0]  bte;
  logic [N-1:0]  m_ack;
  logic [31:0]   m_dat;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]   wb_adr_o, wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_ack_i;
  logic [31:0]   wb_dat_i;
  logic          grant_valid;
  logic [PW-1:0] grant_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, last grant index, round-robin pointer.
  bit m_owned;
  int m_owner, m_gidx, m_last;

  logic [PW-1:0] grants[$];
  bit            prev_gv;
  int            ack1_cnt;
  logic [N-1:0]  ack_seen;
  logic [31:0]   dat_seen;
  bit            beats[N];

  lisnoc_dma_wb_arbiter #(.num_masters(N), .master_ptr_width(PW)) dut (
    .clk(clk), .rst(rst),
    .m_wb_cyc_i(cyc), .m_wb_stb_i(stb), .m_wb_we_i(we),
    .m_wb_adr_i(adr), .m_wb_dat_i(dat), .m_wb_sel_i(sel),
    .m_wb_cti_i(cti), .m_wb_bte_i(bte),
    .m_wb_ack_o(m_ack), .m_wb_dat_o(m_dat),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 0;
    m_owner = 0;
    m_gidx  = 0;
    m_last  = N - 1;
  endtask

  // Rule: first requester found walking last+1, last+2, ... modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] e_ack;
    e_ack = '0;
    if (m_owned) e_ack[m_owner] = wb_ack_i;
    chk("grant_valid", grant_valid, m_owned);
    chk("grant_idx", grant_idx, m_gidx);
    chk("m_wb_ack_o", m_ack, e_ack);
    chk("m_wb_dat_o", m_dat, wb_dat_i);
    if (m_owned) begin
      chk("wb_cyc_o", wb_cyc_o, cyc[m_owner]);
      chk("wb_stb_o", wb_stb_o, stb[m_owner]);
      chk("wb_we_o",  wb_we_o,  we[m_owner]);
      chk("wb_adr_o", wb_adr_o, adr[32*m_owner +: 32]);
      chk("wb_dat_o", wb_dat_o, dat[32*m_owner +: 32]);
      chk("wb_sel_o", wb_sel_o, sel[4*m_owner +: 4]);
      chk("wb_cti_o", wb_cti_o, cti[3*m_owner +: 3]);
      chk("wb_bte_o", wb_bte_o, bte[2*m_owner +: 2]);
    end else begin
      chk("idle_port", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}, 32'h0);
      chk("idle_adr_dat", wb_adr_o | wb_dat_o, 32'h0);
    end
  endtask

  // One clock: check at negedge, advance model at posedge, return 1 time unit later.
  task automatic cycle();
    bit n_owned;
    int n_owner, n_gidx, n_last, w;
    @(negedge clk);
    check_outputs();
    if (grant_valid && !prev_gv) grants.push_back(grant_idx);
    prev_gv  = grant_valid;
    ack_seen = m_ack;
    dat_seen = m_dat;
    if (m_ack[1]) ack1_cnt++;
    n_owned = m_owned; n_owner = m_owner; n_gidx = m_gidx; n_last = m_last;
    if (rst) begin
      if (!m_owned) begin
        w = rr_pick(cyc, m_last);
        if (w >= 0) begin
          n_owned = 1; n_owner = w; n_gidx = w; n_last = w;
        end
      end else if (!cyc[m_owner] || (wb_ack_i && cti[3*m_owner +: 3] == WB_CTI_EOB)) begin
        n_owned = 0;
      end
    end
    @(posedge clk);
    m_owned = n_owned; m_owner = n_owner; m_gidx = n_gidx; m_last = n_last;
    #1;
  endtask

  task automatic set_m(input int i, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [2:0] t);
    cyc[i] = c; stb[i] = s; we[i] = w;
    adr[32*i +: 32] = a;
    dat[32*i +: 32] = $urandom;
    sel[4*i +: 4]   = 4'hF;
    cti[3*i +: 3]   = t;
    bte[2*i +: 2]   = WB_BTE_LINEAR;
  endtask

  initial begin
    rst = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0;
    sel = '0; cti = '0; bte = '0;
    wb_ack_i = 1'b0; wb_dat_i = '0;
    prev_gv = 0; ack1_cnt = 0;
    model_reset();

    // Reset held with two requesters: port must stay quiet.
    cyc = 3'b011;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("first_grant_idx", grant_idx, 32'd0);
    cyc = '0;
    cycle();
    cycle();

    // Four-beat write burst from master 1.
    ack1_cnt = 0;
    set_m(1, 1, 1, 1, 32'h100, WB_CTI_INCR);
    cycle();
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1, 1, 1, 32'h100 + 32'(4*b), (b == 3) ? WB_CTI_EOB : WB_CTI_INCR);
      wb_ack_i = 1'b1;
      cycle();
    end
    cyc[1] = 1'b0; wb_ack_i = 1'b0;
    cycle();
    chk("burst_ack1_count", ack1_cnt, 32'd4);

    // Contention with 2-beat bursts: owners must alternate 0,1,0,1.
    grants.delete();
    beats[0] = 0; beats[1] = 0;
    wb_ack_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 2; i++)
        set_m(i, 1, 1, 1, 32'h1000 * (i + 1), beats[i] ? WB_CTI_EOB : WB_CTI_INCR);
      cycle();
      for (int i = 0; i < 2; i++)
        if (ack_seen[i]) beats[i] = ~beats[i];
    end
    cyc = '0; wb_ack_i = 1'b0;
    cycle();
    chk("contention_grants", grants.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("contention_owner", (k < grants.size()) ? 32'(grants[k]) : 32'hFFFF, k % 2);

    // Classic single read by master 0.
    set_m(0, 1, 1, 0, 32'h200, WB_CTI_CLASSIC);
    cycle();
    wb_dat_i = 32'hDEADBEEF; wb_ack_i = 1'b1;
    cycle();
    chk("classic_dat", dat_seen, 32'hDEADBEEF);
    chk("classic_ack", ack_seen, 32'b001);
    cyc = '0; wb_ack_i = 1'b0;
    cycle();
    cycle();

    // Burst by master 1 with a 3-cycle slave stall while master 0 waits.
    set_m(0, 1, 1, 1, 32'h300, WB_CTI_INCR);
    set_m(1, 1, 1, 1, 32'h400, WB_CTI_INCR);
    cycle();
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1, 1, 1, 32'h400 + 32'(4*b), (b == 3) ? WB_CTI_EOB : WB_CTI_INCR);
      if (b == 1) begin
        wb_ack_i = 1'b0;
        repeat (3) cycle();
      end
      wb_ack_i = 1'b1;
      cycle();
    end
    chk("stall_ack0_quiet", ack_seen[0], 32'd0);
    cyc = '0; wb_ack_i = 1'b0;
    cycle();
    cycle();

    // Asynchronous reset in the middle of a burst owned by master 0.
    set_m(0, 1, 1, 1, 32'h500, WB_CTI_INCR);
    set_m(1, 1, 1, 1, 32'h600, WB_CTI_INCR);
    cycle();
    wb_ack_i = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_cyc", wb_cyc_o, 32'd0);
    check_outputs();
    prev_gv = 0;
    repeat (2) cycle();
    rst = 1'b1; wb_ack_i = 1'b0;
    cycle();
    cycle();
    chk("restart_owner", grant_idx, 32'd0);
    cyc = '0;
    cycle();
    cycle();

    // Random traffic from all three masters.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        cyc[i] = ($urandom_range(0, 3) != 0);
        stb[i] = $urandom_range(0, 1) != 0;
        we[i]  = $urandom_range(0, 1) != 0;
        adr[32*i +: 32] = $urandom;
        dat[32*i +: 32] = $urandom;
        sel[4*i +: 4]   = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0:       cti[3*i +: 3] = WB_CTI_CLASSIC;
          1:       cti[3*i +: 3] = WB_CTI_EOB;
          default: cti[3*i +: 3] = WB_CTI_INCR;
        endcase
        bte[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      wb_ack_i = $urandom_range(0, 1) != 0;
      wb_dat_i = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lisnoc_dma_wb_arbiter.md
Name: lisnoc_dma_wb_arbiter

Overview:
- Shares one Wishbone master port of a DMA tile among num_masters requesters: the L2R request-side fetch engine, the NoC response writer and any further requesters.
- Round-robin arbitration; grant held for a whole bus cycle/burst. Response-side writes and request-side reads never interleave within a burst.
- Sits between the DMA initiator sub-blocks and the tile bus interconnect.

Parameters:
- num_masters, 2, number of requesting Wishbone masters (2..8)
- master_ptr_width, 1, width of grant index; must be >= clog2(num_masters), set by instantiator

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- m_wb_cyc_i  in  num_masters  per-master cyc
- m_wb_stb_i  in  num_masters  per-master stb
- m_wb_we_i  in  num_masters  per-master we
- m_wb_adr_i  in  num_masters*32  packed addresses; master i at [32*i+31:32*i]
- m_wb_dat_i  in  num_masters*32  packed write data
- m_wb_sel_i  in  num_masters*4  packed byte selects
- m_wb_cti_i  in  num_masters*3  packed cycle type
- m_wb_bte_i  in  num_masters*2  packed burst type
- m_wb_ack_o  out  num_masters  per-master ack
- m_wb_dat_o  out  32  read data, broadcast to all masters
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  shared port controls
- wb_adr_o  out  32  shared port address
- wb_dat_o  out  32  shared port write data
- wb_sel_o  out  4  shared port byte selects
- wb_cti_o  out  3  shared port cycle type
- wb_bte_o  out  2  shared port burst type
- wb_ack_i  in  1  slave ack
- wb_dat_i  in  32  slave read data
- grant_valid  out  1  a master currently owns the bus
- grant_idx  out  master_ptr_width  index of the owner

Behaviour:
- Registers:
  - state: IDLE/OWNED
  - grant_idx
  - last_idx: previous owner, round-robin pointer
- Reset (rst=0, asynchronous):
  - state=IDLE, grant_valid=0, grant_idx=0, last_idx=num_masters-1, so master 0 wins first.
  - All wb_*_o=0, all m_wb_ack_o=0.
  - m_wb_dat_o passes wb_dat_i unconditionally.
- IDLE:
  - Requesters are the masters with m_wb_cyc_i=1.
  - If any, the winner is the first requester searching last_idx+1, last_idx+2, ... modulo num_masters.
  - Next edge: state=OWNED, grant_idx=winner, last_idx=winner.
  - No shared-port activity in IDLE: wb_cyc_o=wb_stb_o=0, all acks 0.
- Latency:
  - Request visible at edge N gives grant_valid=1 after edge N+1, one dead cycle.
  - The first stb can complete in the cycle after grant.
- OWNED:
  - All wb_*_o combinationally copy the grant_idx master's fields.
  - m_wb_ack_o[grant_idx]=wb_ack_i; all other acks 0.
- Release from OWNED to IDLE at the next edge when either holds:
  - owner cyc=0, or
  - wb_ack_i=1 with owner cti=3'b111 (end of burst).
- Release cycle:
  - The terminating ack is delivered normally.
  - The following cycle is IDLE, one dead cycle.
  - The previous owner requesting again competes at lowest priority.
- Owner drops cyc while the slave asserts ack: ack passed through (slave view), then release.
- Non-owner toggling cyc/stb: no effect on the port and no ack.
- Fields of masters with idx >= num_masters are never selected.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,n-1,0.

Decomposition:
- lisnoc_dma_def.vh gains CTI constants: WB_CTI_CLASSIC=3'b000, WB_CTI_INCR=3'b010, WB_CTI_EOB=3'b111, and WB_BTE_LINEAR=2'b00.
- One sub-module, lisnoc_arb_rr: purely combinational round-robin next-owner search (req vector, last index -> winner index, any).
  - Parameterised on width.
  - Reusable by router output arbitration.

Test Plan:
- Reset: hold rst=0 with m_wb_cyc_i=2'b11 -> wb_cyc_o=0, acks 0. Release -> master 0 granted after 1 edge, grant_idx=0.
- Single burst: master 1 writes 4 beats at 0x100 (cti 010,010,010,111), slave acks each cycle.
  - wb_adr_o follows 0x100..0x10C and only m_wb_ack_o[1] pulses 4 times.
  - grant_valid drops the cycle after the 4th ack.
- Contention: both request continuously with 2-beat bursts -> owner sequence 0,1,0,1, one idle cycle between grants, m_wb_ack_o[0] never set during master 1 ownership.
- Classic cycle: master 0 does a single read, cti=000, slave returns 0xDEADBEEF.
  - m_wb_dat_o=0xDEADBEEF with ack.
  - Release when cyc drops after the next edge.
- Wait states: slave stalls ack 3 cycles mid-burst -> grant held, outputs stable, no spurious ack to the other requester.
- Mid-burst reset: assert rst=0 during OWNED beat 2 -> wb_cyc_o=0 immediately (async). After release, arbitration restarts at master 0.
